// File: rtl/i2c_arbiter.sv
// Two-port round-robin arbiter in front of a shared I2C send engine: port 0 is the
// boot configuration sequencer, port 1 the runtime register writer gated by en1.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT = 2500000
) (
    input  logic        clk_25M,
    input  logic        rst_100,
    input  logic        req0,
    input  logic [31:0] data0,
    output logic        done0,
    output logic        err0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        done1,
    output logic        err1,
    input  logic        en1,
    output logic        m_req,
    output logic [31:0] m_data,
    input  logic        m_ack,
    output logic        busy,
    output logic        grant_id
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE, DONE} state_t;

    localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        m_req_q, m_req_d;
    logic [31:0] m_data_q, m_data_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [23:0] wd_q, wd_d;

    logic elig0, elig1, sel, wd_expired;

    assign elig0      = req0;
    assign elig1      = req1 & en1;
    assign sel        = (elig0 & elig1) ? ~last_q : elig1;
    // A compare of >= keeps RELEASE bounded even when the ack lands on the last WAIT_ACK cycle.
    assign wd_expired = (wd_q >= WD_LIMIT);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d  = state_q;
        m_req_d  = m_req_q;
        m_data_d = m_data_q;
        grant_d  = grant_q;
        last_d   = last_q;
        busy_d   = busy_q;
        err_d    = err_q;
        wd_d     = wd_q;
        unique case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d  = WAIT_ACK;
                    m_req_d  = 1'b1;
                    m_data_d = sel ? data1 : data0;
                    grant_d  = sel;
                    last_d   = sel;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    wd_d     = '0;
                end
            end
            WAIT_ACK: begin
                wd_d = wd_q + 24'd1;
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = RELEASE;
                end else if (wd_expired) begin
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RELEASE: begin
                wd_d = wd_q + 24'd1;
                if (!m_ack) begin
                    state_d = DONE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_25M or negedge rst_100) begin
        if (!rst_100) begin
            state_q  <= IDLE;
            m_req_q  <= 1'b0;
            m_data_q <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            m_req_q  <= m_req_d;
            m_data_q <= m_data_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_data   = m_data_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign done0    = (state_q == DONE) & ~grant_q;
    assign done1    = (state_q == DONE) &  grant_q;
    assign err0     = done0 & err_q;
    assign err1     = done1 & err_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus a randomized loop,
// checked against a transaction-level model of grant order and completion timing.
module tb_i2c_arbiter;
    localparam int TO = 16;

    logic        clk_25M = 1'b0;
    logic        rst_100;
    logic        req0, req1, en1, m_ack;
    logic [31:0] data0, data1;
    logic        done0, err0, done1, err1;
    logic        m_req, busy, grant_id;
    logic [31:0] m_data;

    int n_assert = 0;
    int n_fail   = 0;
    int txn      = 0;
    int last     = 1;
    int p;

    i2c_arbiter #(.TIMEOUT(TO)) dut (
        .clk_25M (clk_25M),
        .rst_100 (rst_100),
        .req0    (req0),
        .data0   (data0),
        .done0   (done0),
        .err0    (err0),
        .req1    (req1),
        .data1   (data1),
        .done1   (done1),
        .err1    (err1),
        .en1     (en1),
        .m_req   (m_req),
        .m_data  (m_data),
        .m_ack   (m_ack),
        .busy    (busy),
        .grant_id(grant_id)
    );

    always #5 clk_25M = ~clk_25M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("t%0d_%s_k%0d", txn, s, k);
    endfunction

    function automatic logic done_of(input int q);
        return (q == 1) ? done1 : done0;
    endfunction

    function automatic logic err_of(input int q);
        return (q == 1) ? err1 : err0;
    endfunction

    // Round-robin rule: on a tie the port not granted last wins.
    function automatic int pick(input bit e0, input bit e1);
        if (e0 && e1) return (last == 0) ? 1 : 0;
        return e1 ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk_25M);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_m_req"}, m_req, 1'b0);
        chk({tag, "_m_data"}, m_data, 32'h0);
        chk1({tag, "_done0"}, done0, 1'b0);
        chk1({tag, "_done1"}, done1, 1'b0);
        chk1({tag, "_err0"}, err0, 1'b0);
        chk1({tag, "_err1"}, err1, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_grant_id"}, grant_id, 1'b0);
    endtask

    // Called in an IDLE cycle whose closing edge grants port p with word dat.
    // The engine raises m_ack d cycles after the grant cycle for len cycles.
    task automatic transact(input int p_i, input logic [31:0] dat, input int d,
                            input int len, input bit early);
        int  done_k, fall_k, e, c0;
        bit  err_e;
        txn++;
        if (d > TO - 1) begin
            done_k = TO;
            fall_k = TO;
            err_e  = 1'b1;
        end else begin
            e  = d + 1;
            c0 = d + len;
            while (e < c0 && e < TO - 1) e++;
            done_k = e + 1;
            fall_k = d + 1;
            err_e  = (e < c0);
        end
        step();
        for (int k = 0; k <= done_k; k++) begin
            if (k > 0) step();
            chk1(tg("m_req", k), m_req, k < fall_k);
            chk1(tg("busy", k), busy, 1'b1);
            chk1(tg("grant_id", k), grant_id, p_i[0]);
            chk(tg("m_data", k), m_data, dat);
            chk1(tg("done_g", k), done_of(p_i), k == done_k);
            chk1(tg("err_g", k), err_of(p_i), (k == done_k) && err_e);
            chk1(tg("done_o", k), done_of(1 - p_i), 1'b0);
            chk1(tg("err_o", k), err_of(1 - p_i), 1'b0);
            if (k == done_k) begin
                if (p_i == 0) req0 = 1'b0; else req1 = 1'b0;
                m_ack = 1'($urandom_range(0, 1));
            end else begin
                m_ack = (k >= d && k < d + len);
            end
            if (early && k == 1) begin
                if (p_i == 0) req0 = 1'b0;
                else begin
                    req1 = 1'b0;
                    en1  = 1'b0;
                end
            end
            if (p_i == 0) data1 = $urandom; else data0 = $urandom;
        end
        step();
        chk1(tg("idle_busy", 99), busy, 1'b0);
        chk1(tg("idle_m_req", 99), m_req, 1'b0);
        chk1(tg("idle_done0", 99), done0, 1'b0);
        chk1(tg("idle_done1", 99), done1, 1'b0);
        chk1(tg("idle_err0", 99), err0, 1'b0);
        chk1(tg("idle_err1", 99), err1, 1'b0);
    endtask

    initial begin
        rst_100 = 1'b1;
        req0 = 1'b0; req1 = 1'b0; en1 = 1'b0; m_ack = 1'b0;
        data0 = 32'h0; data1 = 32'h0;
        #2 rst_100 = 1'b0;
        #2 chk_all_zero("reset");

        // Request pending while reset is held must not be granted.
        req0  = 1'b1;
        data0 = 32'h78310311;
        step();
        step();
        chk1("reset_hold_m_req", m_req, 1'b0);
        chk1("reset_hold_busy", busy, 1'b0);
        rst_100 = 1'b1;

        p = pick(1'b1, 1'b0);
        transact(p, 32'h78310311, 5, 1, 1'b0);
        last = p;

        // Minimum-latency handshake.
        req0  = 1'b1;
        data0 = $urandom;
        p = pick(1'b1, 1'b0);
        transact(p, data0, 1, 1, 1'b0);
        last = p;

        // Both ports held continuously: grants must alternate.
        req0 = 1'b1; req1 = 1'b1; en1 = 1'b1;
        data0 = $urandom; data1 = $urandom;
        for (int i = 0; i < 4; i++) begin
            p = pick(1'b1, 1'b1);
            transact(p, (p == 1) ? data1 : data0, int'($urandom_range(1, 6)),
                     int'($urandom_range(1, 4)), 1'b0);
            last = p;
            if (p == 0) begin req0 = 1'b1; data0 = $urandom; end
            else begin req1 = 1'b1; data1 = $urandom; end
        end
        req0 = 1'b0; req1 = 1'b0;

        // Port 1 blocked by en1 for 100 cycles; stray acks in IDLE are ignored.
        req1 = 1'b1; en1 = 1'b0; data1 = $urandom;
        for (int i = 0; i < 100; i++) begin
            m_ack = 1'($urandom_range(0, 1));
            step();
            chk({"en1_block_", $sformatf("%0d", i)}, {30'b0, m_req, busy}, 32'h0);
        end
        en1 = 1'b1;
        p = pick(1'b0, 1'b1);
        // en1 and req1 fall mid-transaction; it still completes.
        transact(p, data1, 3, 2, 1'b1);
        last = p;

        // Engine never acknowledges.
        req0 = 1'b1; req1 = 1'b0; data0 = $urandom;
        p = pick(1'b1, 1'b0);
        transact(p, data0, 100, 1, 1'b0);
        last = p;

        // Engine ack stuck high after the first ack.
        req0 = 1'b0; req1 = 1'b1; en1 = 1'b1; data1 = $urandom;
        p = pick(1'b0, 1'b1);
        transact(p, data1, 2, 100, 1'b0);
        last = p;

        for (int i = 0; i < 30; i++) begin
            bit r0, r1, e1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 1));
            req0 = r0; req1 = r1; en1 = e1;
            data0 = $urandom; data1 = $urandom;
            m_ack = 1'($urandom_range(0, 1));
            if (!(r0 || (r1 && e1))) begin
                step();
                chk({"rand_idle_", $sformatf("%0d", i)}, {30'b0, m_req, busy}, 32'h0);
            end else begin
                p = pick(r0, r1 && e1);
                transact(p, (p == 1) ? data1 : data0, int'($urandom_range(1, 18)),
                         int'($urandom_range(1, 18)), $urandom_range(0, 3) == 0);
                last = p;
            end
        end

        // Reset asserted mid-transaction clears outputs without a clock edge.
        req0 = 1'b1; req1 = 1'b0; data0 = $urandom; m_ack = 1'b0;
        step();
        chk1("rst_mid_m_req", m_req, 1'b1);
        chk1("rst_mid_grant", grant_id, 1'b0);
        step();
        step();
        #2 rst_100 = 1'b0;
        #1 chk_all_zero("rst_async");
        step();
        step();
        chk_all_zero("rst_held");
        rst_100 = 1'b1;
        last = 1;
        p = pick(1'b1, 1'b0);
        transact(p, data0, 4, 2, 1'b0);
        last = p;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 2500000, which sets the slave-ack watchdog limit in clk_25M cycles (100 ms).
REQ-002 SHALL have port clk_25M, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_100, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req0, input, 1 bit: port-0 (boot configuration sequencer) request level.
REQ-005 SHALL have port data0, input, 32 bits: port-0 transfer word {dev_addr[7:0], reg_addr[15:0], value[7:0]}.
REQ-006 SHALL have ports done0 and err0, outputs, 1 bit each: port-0 completion pulse and error flag.
REQ-007 SHALL have ports req1 and data1, inputs, 1 bit and 32 bits: port-1 (runtime register writer) request and word.
REQ-008 SHALL have ports done1 and err1, outputs, 1 bit each: port-1 completion pulse and error flag.
REQ-009 SHALL have port en1, input, 1 bit: port-1 enable; driven by the configuration-done flag.
REQ-010 SHALL have ports m_req and m_data, outputs, 1 bit and 32 bits: request and word to the shared I2C send engine.
REQ-011 SHALL have port m_ack, input, 1 bit: engine acknowledge, already synchronous to clk_25M.
REQ-012 SHALL have ports busy and grant_id, outputs, 1 bit each: transaction active, and the index of the granted port.

Function
REQ-013 SHALL implement the states IDLE, WAIT_ACK, RELEASE and DONE.
REQ-014 SHALL, in IDLE, treat a port as eligible when req0=1, or when req1=1 and en1=1.
REQ-015 SHALL, when both ports are eligible, grant the port not granted last (round-robin); last_grant resets to 1, so port 0 wins the first tie.
REQ-016 SHALL, on the edge after an IDLE cycle with an eligible port, set m_req=1, m_data=selected word, grant_id=port, busy=1, last_grant=port, and enter WAIT_ACK.
REQ-017 SHALL hold m_data and grant_id constant from grant until IDLE is re-entered; requester data changes during this time are ignored.
REQ-018 SHALL, in WAIT_ACK, on m_ack=1, clear m_req on the next edge and enter RELEASE.
REQ-019 SHALL, in RELEASE, on m_ack=0, enter DONE (4-phase handshake).
REQ-020 SHALL, in DONE, drive done[grant_id]=1 for exactly one cycle, then enter IDLE with busy=0.
REQ-021 SHALL, in the same DONE cycle, drive err[grant_id]=1 only if the transaction timed out, else 0.
REQ-022 SHALL require each requester to hold req and data until it samples done, then drop req on that same edge; the arbiter does not re-grant a port during its DONE cycle.
REQ-023 SHALL run a 24-bit watchdog counter that clears on entry to WAIT_ACK and increments in WAIT_ACK and RELEASE.
REQ-024 SHALL, when the watchdog reaches TIMEOUT-1 in WAIT_ACK (no ack) or RELEASE (ack stuck high), force m_req=0 and enter DONE with err set.
REQ-025 SHALL complete a granted port-1 transaction normally if en1 falls mid-transaction; en1 gates only new grants.
REQ-026 SHALL give minimum latency, with m_ack answering in 1 cycle, of: req cycle N -> m_req cycle N+1 -> done cycle N+4.
REQ-027 SHALL ignore an m_ack seen while in IDLE or DONE.
REQ-028 SHALL treat a requester deasserting req before its done as a protocol violation; the arbiter still completes that transaction and pulses done.

Reset
REQ-029 SHALL, on rst_100=0, immediately force m_req, m_data, done0/1, err0/1, busy, grant_id and the watchdog to 0, set last_grant=1, and enter IDLE, even mid-transaction.
REQ-030 SHALL, on reset release, start its first grant no earlier than the first edge at which rst_100=1 is sampled.

Verification
REQ-031 SHALL be verified with: req0=1, data0=32'h78310311, engine acks after 5 cycles -> m_data=32'h78310311, one done0 pulse, err0=0, busy falls after DONE.
REQ-032 SHALL be verified with: req0 and req1 held continuously, en1=1 -> grants alternate 0,1,0,1, and no port gets two consecutive grants.
REQ-033 SHALL be verified with: req1=1 while en1=0 for 100 cycles -> no grant; en1 raised -> grant to port 1 on the next edge.
REQ-034 SHALL be verified with: TIMEOUT=16, m_ack tied 0 -> m_req drops 16 cycles after grant, and done0=err0=1 for one cycle.
REQ-035 SHALL be verified with: TIMEOUT=16, m_ack stuck 1 after the first ack -> RELEASE times out, and err pulses with done.
REQ-036 SHALL be verified with: rst_100 asserted while in WAIT_ACK -> all outputs 0 asynchronously; after release, a pending req0 is granted normally.
